// File: rtl/pid_pkg.sv
// pid_sched shared types: FSM state encoding and
// default timing / slew constants.
package pid_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_CALC,
    S_TICK
  } state_t;

  localparam int unsigned DEF_TICK_W = 20;
  localparam int unsigned DEF_PED_TO = 4;
  localparam logic [11:0] DEF_SLEW   = 12'h010;
  localparam int unsigned DEF_A2D_TO = 255;

endpackage

// File: rtl/pid_sched_slew_lim.sv
// slew_lim: one combinational step from i_cur toward i_tgt,
// never more than SLEW. Ports: i_cur, i_tgt in; o_nxt out.
module slew_lim
  import pid_pkg::*;
#(
  parameter logic [11:0] SLEW = DEF_SLEW
) (
  input  logic [11:0] i_cur,
  input  logic [11:0] i_tgt,
  output logic [11:0] o_nxt
);

  logic [11:0] w_up;
  logic [11:0] w_dn;

  assign w_up = i_tgt - i_cur;
  assign w_dn = i_cur - i_tgt;

  // Step is clipped to the remaining distance: no overshoot, no wrap.
  always_comb begin
    o_nxt = i_cur;
    if (i_tgt > i_cur)
      o_nxt = i_cur + ((w_up > SLEW) ? SLEW : w_up);
    else if (i_tgt < i_cur)
      o_nxt = i_cur - ((w_dn > SLEW) ? SLEW : w_dn);
  end

endmodule

// File: rtl/pid_sched.sv
// pid_sched: paces torque sampling and PID updates, tracks
// rider idle, slew-limits the motor drive.
// In: clk, rst_n, cadence, a2d_rdy, a2d_data, target, drv_raw.
// Out: a2d_req, error, pid_tick, not_pedaling, drv_mag, a2d_fault.
module pid_sched
  import pid_pkg::*;
#(
  parameter int unsigned TICK_W = DEF_TICK_W,
  parameter int unsigned PED_TO = DEF_PED_TO,
  parameter logic [11:0] SLEW   = DEF_SLEW,
  parameter int unsigned A2D_TO = DEF_A2D_TO
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cadence,
  input  logic        a2d_rdy,
  input  logic [11:0] a2d_data,
  input  logic [11:0] target,
  input  logic [11:0] drv_raw,
  output logic        a2d_req,
  output logic [12:0] error,
  output logic        pid_tick,
  output logic        not_pedaling,
  output logic [11:0] drv_mag,
  output logic        a2d_fault
);

  localparam int unsigned WW = $clog2(A2D_TO + 1);
  localparam int unsigned CW = $clog2(PED_TO + 1);

  state_t            r_st;
  logic [TICK_W-1:0] r_tick;
  logic [WW-1:0]     r_wcnt;
  logic [11:0]       r_torque;
  logic [12:0]       r_err;
  logic              r_req;
  logic              r_ptick;
  logic              r_fault;
  logic              r_cad_d;
  logic [CW-1:0]     r_idle;
  logic [11:0]       r_drv;

  logic              w_due;
  logic              w_rise;
  logic              w_np;
  logic [11:0]       w_nxt;

  assign w_due  = &r_tick;
  assign w_rise = cadence & ~r_cad_d;
  assign w_np   = (r_idle == CW'(PED_TO));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_tick <= '0;
    else        r_tick <= r_tick + 1'b1;
  end

  // Strobes are registered from the state, so each one
  // lands in the cycle after its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st     <= S_IDLE;
      r_wcnt   <= '0;
      r_torque <= '0;
      r_err    <= '0;
      r_req    <= 1'b0;
      r_ptick  <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_req   <= (r_st == S_REQ);
      r_ptick <= (r_st == S_TICK);
      unique case (r_st)
        S_IDLE: begin
          if (w_due) r_st <= S_REQ;
        end
        S_REQ: begin
          r_wcnt <= '0;
          r_st   <= S_WAIT;
        end
        S_WAIT: begin
          if (a2d_rdy) begin
            r_torque <= a2d_data;
            r_st     <= S_CALC;
          end else if (r_wcnt == WW'(A2D_TO - 1)) begin
            // Timeout: keep the old torque, still update.
            r_fault <= 1'b1;
            r_st    <= S_CALC;
          end else begin
            r_wcnt <= r_wcnt + 1'b1;
          end
        end
        S_CALC: begin
          r_err <= {1'b0, target} - {1'b0, r_torque};
          r_st  <= S_TICK;
        end
        S_TICK: begin
          r_st <= S_IDLE;
        end
        default: begin
          r_st <= S_IDLE;
        end
      endcase
    end
  end

  slew_lim #(
    .SLEW (SLEW)
  ) u_slew (
    .i_cur (r_drv),
    .i_tgt (drv_raw),
    .o_nxt (w_nxt)
  );

  // Cadence edge wins over a same-cycle tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cad_d <= 1'b0;
      r_idle  <= CW'(PED_TO);
      r_drv   <= '0;
    end else begin
      r_cad_d <= cadence;
      if (w_rise)
        r_idle <= '0;
      else if (r_ptick && !w_np)
        r_idle <= r_idle + 1'b1;
      if (w_np)
        r_drv <= '0;
      else if (r_ptick)
        r_drv <= w_nxt;
    end
  end

  assign a2d_req      = r_req;
  assign pid_tick     = r_ptick;
  assign error        = r_err;
  assign a2d_fault    = r_fault;
  assign not_pedaling = w_np;
  assign drv_mag      = r_drv;

endmodule

// File: doc/pid_sched.md
PID_SCHED -- requirements
Module: pid_sched

Interface
REQ-001 Parameter TICK_W, default 20, width of free-running tick counter; one update tick every 2^TICK_W clk cycles (about 1/48 s at 50 MHz).
REQ-002 Parameter PED_TO, default 4, number of update ticks without a cadence rising edge before not_pedaling asserts.
REQ-003 Parameter SLEW, default 12'h010, maximum drv_mag change per update tick.
REQ-004 Parameter A2D_TO, default 255, maximum clk cycles spent waiting for a2d_rdy.
REQ-005 clk  in  1  system clock, all flops posedge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 cadence  in  1  synchronized cadence sensor level.
REQ-008 a2d_rdy  in  1  single-cycle strobe; torque sample valid.
REQ-009 a2d_data  in  12  unsigned torque sample.
REQ-010 target  in  12  unsigned torque target.
REQ-011 drv_raw  in  12  unsigned drive magnitude from the PID datapath.
REQ-012 a2d_req  out  1  single-cycle conversion request.
REQ-013 error  out  13  signed error (target - torque) held to the PID.
REQ-014 pid_tick  out  1  single-cycle PID update strobe.
REQ-015 not_pedaling  out  1  rider-idle flag.
REQ-016 drv_mag  out  12  slew-limited motor drive.
REQ-017 a2d_fault  out  1  sticky conversion-timeout flag.

Function
REQ-018 Tick counter: TICK_W bits, increments every cycle, wraps; tick_due is asserted when the counter is all-ones.
REQ-019 FSM states IDLE, REQ, WAIT, CALC, TICK; reset state IDLE.
REQ-020 IDLE->REQ on tick_due; otherwise stay.
REQ-021 REQ: a2d_req=1 for exactly that cycle; REQ->WAIT unconditionally.
REQ-022 WAIT: on a2d_rdy latch a2d_data into torque register, ->CALC; after A2D_TO cycles without a2d_rdy set a2d_fault, keep previous torque, ->CALC.
REQ-023 CALC: error <= {1'b0,target} - {1'b0,torque}, 13-bit two's complement with no saturation; ->TICK.
REQ-024 TICK: pid_tick=1 for exactly one cycle; ->IDLE.
REQ-025 tick_due while not in IDLE is dropped; no queuing.
REQ-026 a2d_rdy outside WAIT is ignored.
REQ-027 Cadence rising edge (one-cycle-delayed compare) clears the idle-tick counter; on each pid_tick the idle-tick counter increments, saturating at PED_TO.
REQ-028 not_pedaling=1 when idle-tick count equals PED_TO; a cadence edge in the same cycle as pid_tick takes priority (count cleared).
REQ-029 drv_mag updates only in the cycle after pid_tick: if drv_raw > drv_mag, add min(SLEW, difference); if smaller, subtract min(SLEW, difference); if equal, hold; no wrap-around permitted.
REQ-030 not_pedaling=1 forces drv_mag to 0 on the next clk, overriding slew; slew resumes from 0 when it clears.
REQ-031 a2d_fault clears only on reset.

Reset
REQ-032 Asynchronous assertion of rst_n returns the FSM to IDLE, clears the tick counter, torque, error, drv_mag and a2d_fault to 0, sets the idle-tick counter to PED_TO (not_pedaling=1), and holds a2d_req=0 and pid_tick=0.
REQ-033 Reset mid-WAIT abandons the conversion; a late a2d_rdy is ignored.

Structure
REQ-034 A shared package pid_pkg holds the FSM state enum and the default constants TICK_W, PED_TO, SLEW and A2D_TO.
REQ-035 One sub-module, slew_lim (a combinational step toward its target, bounded by SLEW), instantiated once.

Verification
REQ-036 With TICK_W=4 and a2d_rdy returned 3 cycles after a2d_req: a2d_req occurs every 16 cycles and pid_tick occurs 6 cycles after a2d_req.
REQ-037 target=12'h800 with a2d_data=12'h100 gives error=13'h0700; target=12'h000 with a2d_data=12'hFFF gives error=13'h1001.
REQ-038 drv_raw=12'h0FF from drv_mag=0 with SLEW=16: drv_mag steps 0x010 per tick and reaches 0x0FF after 16 ticks with no overshoot.
REQ-039 Cadence stopped with PED_TO=4: not_pedaling rises at the 4th tick and drv_mag is 0 on the next cycle; one cadence edge clears not_pedaling.
REQ-040 a2d_rdy never returned with A2D_TO=8: a2d_fault sets, pid_tick still fires using the previous error, and the next cycle proceeds normally.
REQ-041 rst_n pulsed low during WAIT: all outputs take their reset values immediately, and an a2d_rdy after release is ignored until the next a2d_req.
